// File: rtl/sik_thread_sched.sv
// Two-thread round-robin issue scheduler: owns both thread PCs and picks the issuing thread each cycle.
// Latency: selection sampled at posedge, fetch address/issue info registered and visible after that edge.
// Backpressure: stall freezes selection/outputs; redirects and halts still apply and squash the held issue.
//
// Ports: clk/reset (async active-high); stall; redir_valid/redir_tid/redir_pc and halt_req/halt_tid from
// execute; imem_addr/issue_valid/issue_tid issue slot; thread_halted, halted, issue_count status.
module sik_thread_sched #(
    parameter logic [15:0] PC0_INIT = 16'h0000,
    parameter logic [15:0] PC1_INIT = 16'h8000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redir_valid,
    input  logic        redir_tid,
    input  logic [15:0] redir_pc,
    input  logic        halt_req,
    input  logic        halt_tid,
    output logic [15:0] imem_addr,
    output logic        issue_valid,
    output logic        issue_tid,
    output logic [1:0]  thread_halted,
    output logic        halted,
    output logic [15:0] issue_count
);

    logic [15:0] pc0, pc1;
    logic        last_tid;

    logic [1:0]  halt_hit;
    logic [1:0]  redir_hit;
    logic [1:0]  redir_apply;
    logic [1:0]  elig;
    logic        pref;
    logic        do_issue;
    logic        sel_tid;
    logic        squash;

    always_comb begin
        halt_hit  = 2'b00;
        redir_hit = 2'b00;
        if (halt_req)    halt_hit[halt_tid]   = 1'b1;
        if (redir_valid) redir_hit[redir_tid] = 1'b1;

        // A thread being halted or redirected this edge cannot issue from its stale PC.
        elig = ~thread_halted & ~halt_hit & ~redir_hit;

        // Halt beats redirect on the same thread, and a halted thread ignores redirects.
        redir_apply = redir_hit & ~thread_halted & ~halt_hit;

        pref     = ~last_tid;
        do_issue = 1'b0;
        sel_tid  = pref;
        if (!stall) begin
            if (elig[pref]) begin
                do_issue = 1'b1;
                sel_tid  = pref;
            end else if (elig[~pref]) begin
                do_issue = 1'b1;
                sel_tid  = ~pref;
            end
        end

        // The held issue slot is killed if its owner is redirected or halted while stalled.
        squash = issue_valid && (halt_hit[issue_tid] || redir_hit[issue_tid]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc0           <= PC0_INIT;
            pc1           <= PC1_INIT;
            last_tid      <= 1'b1;
            imem_addr     <= 16'h0000;
            issue_valid   <= 1'b0;
            issue_tid     <= 1'b0;
            thread_halted <= 2'b00;
            halted        <= 1'b0;
            issue_count   <= 16'h0000;
        end else begin
            if (do_issue) begin
                imem_addr   <= sel_tid ? pc1 : pc0;
                issue_tid   <= sel_tid;
                issue_valid <= 1'b1;
                last_tid    <= sel_tid;
                issue_count <= issue_count + 16'd1;
            end else if (!stall || squash) begin
                issue_valid <= 1'b0;
            end

            if (redir_apply[0])
                pc0 <= redir_pc;
            else if (do_issue && !sel_tid)
                pc0 <= pc0 + 16'd1;

            if (redir_apply[1])
                pc1 <= redir_pc;
            else if (do_issue && sel_tid)
                pc1 <= pc1 + 16'd1;

            thread_halted <= thread_halted | halt_hit;
            // Registered from the current flags, so it trails the last halt by one edge.
            halted        <= &thread_halted;
        end
    end

endmodule

// File: doc/sik_thread_sched.md
# sik_thread_sched

Two-thread issue scheduler for the SIK pipelined stack processor. Owns both thread program counters and, each cycle, picks which hardware thread issues into the shared decode/ALU pipeline. Round-robin alternation; skips halted threads, absorbs redirects (jump/call/ret) and halt requests from the execute stage, and honours pipeline stall. Drives the instruction-memory fetch address and reports the global halt.

## Interface
- PC0_INIT, 16'h0000, reset PC of thread 0
- PC1_INIT, 16'h8000, reset PC of thread 1
- clk  in  1  clock, all state on posedge
- reset  in  1  asynchronous, active-high; clears all state immediately
- stall  in  1  pipeline cannot accept a new issue this cycle
- redir_valid  in  1  execute stage resolved a control transfer
- redir_tid  in  1  thread being redirected
- redir_pc  in  16  new PC for redir_tid
- halt_req  in  1  execute stage retired sys/halt
- halt_tid  in  1  thread being halted
- imem_addr  out  16  fetch address of issued instruction
- issue_valid  out  1  imem_addr/issue_tid describe a live issue
- issue_tid  out  1  thread owning the issue slot
- thread_halted  out  2  per-thread halted flags
- halted  out  1  both threads halted
- issue_count  out  16  total issues since reset

## Operation
- State: pc0, pc1 (16b), last_tid (1b), thread_halted[1:0], output registers. Per-thread status is RUN or HALTED; HALTED is terminal until reset.
- Reset values: pc0=PC0_INIT, pc1=PC1_INIT, last_tid=1 (thread 0 issues first), imem_addr=0, issue_valid=0, issue_tid=0, thread_halted=2'b00, halted=0, issue_count=0.
- Eligibility of thread t at an edge: !thread_halted[t] && !(halt_req && halt_tid==t) && !(redir_valid && redir_tid==t).
- Selection (when !stall): preferred = ~last_tid; issue preferred if eligible, else the other if eligible, else no issue.
- On issue of t: imem_addr<=pc_t, issue_tid<=t, issue_valid<=1, pc_t<=pc_t+1 (16-bit wrap, FFFF->0000), last_tid<=t, issue_count<=issue_count+1 (wraps).
- No issue: issue_valid<=0; imem_addr, issue_tid, last_tid unchanged.
- Redirect: pc[redir_tid]<=redir_pc; takes priority over increment; redirected thread not issued that edge; its next issue fetches redir_pc. Redirect to a halted thread ignored.
- Halt: thread_halted[halt_tid]<=1. Halt and redirect to same thread same edge: halt wins, pc unchanged.
- Redirects and halts apply regardless of stall.
- Stall: no new selection; outputs and pcs hold, except squash: if issue_valid && (redirect or halt targets issue_tid) that edge, issue_valid<=0.
- halted<=&thread_halted (registered from current flags; one edge after the second flag sets).

## Timing
- All outputs registered; decision sampled at posedge, visible after that edge.
- Fetch latency: PC selected at edge N appears on imem_addr after edge N; instruction memory is the consumer's responsibility.
- Both threads running, no stall/redirect: issue_tid alternates 0,1,0,1… with issue_valid=1 every cycle.
- One thread halted: remaining thread issues every cycle (back-to-back).
- Redirect at edge N: target thread skipped at N, eligible at N+1.
- halted rises exactly one edge after the edge that sets the last thread_halted bit; once high, stays high until reset.
- Reset asserted mid-run: all state returns to reset values asynchronously; first issue is thread 0 at PC0_INIT on first edge after deassertion.

## Test plan
- Reset then 4 edges, no stall -> imem_addr 0000,8000,0001,8001; issue_tid 0,1,0,1; issue_count=4.
- halt_req tid=1 at edge 2 -> thread_halted=2'b10; subsequent issues all tid 0 at consecutive PCs; halted stays 0.
- redir_valid tid=0 pc=0040 on an edge where thread 0 preferred -> thread 1 issues that edge; next thread-0 issue imem_addr=0040, then 0041.
- stall high 3 edges with issue_valid=1 -> outputs and issue_count frozen; redirect to issue_tid during stall -> issue_valid drops to 0; on stall release, redirected PC issued.
- halt tid 0 and tid 1 on successive edges -> issue_valid=0 after, halted=1 one edge after second halt; redirect afterwards ignored.
- pc1 forced via redirect to FFFF, issue twice -> imem_addr FFFF then 0000 for thread 1; reset pulse mid-sequence -> all outputs zero, next issue tid 0 at 0000.
